// File: rtl/cprv_lsu_stage.sv
// cprv memory stage: in-order completion queue with several outstanding dmem requests,
// byte-lane store strobes, load extraction with sign/zero extension, and flagging of
// misaligned or illegal-size accesses without issuing them to dmem.
module cprv_lsu_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // ex -> lsu
  input  logic                    valid_mem_i,
  output logic                    ready_mem_o,
  input  logic [6:0]              opcode_mem_i,
  input  logic [2:0]              funct3_mem_i,
  input  logic [4:0]              rd_addr_mem_i,
  input  logic                    rd_en_mem_i,
  input  logic [DATA_WIDTH-1:0]   alu_out_mem_i,
  input  logic [DATA_WIDTH-1:0]   rs2_data_mem_i,
  // lsu -> dmem request
  output logic                    valid_dmem_o,
  input  logic                    ready_dmem_i,
  output logic [DATA_WIDTH-1:0]   addr_dmem_o,
  output logic [DATA_WIDTH-1:0]   wdata_dmem_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_dmem_o,
  output logic                    w_en_dmem_o,
  // dmem -> lsu response
  input  logic                    valid_rsp_dmem_i,
  output logic                    ready_rsp_dmem_o,
  input  logic [DATA_WIDTH-1:0]   rdata_rsp_dmem_i,
  // lsu -> wb
  output logic                    valid_wb_o,
  input  logic                    ready_wb_i,
  output logic [4:0]              rd_addr_wb_o,
  output logic                    rd_en_wb_o,
  output logic [DATA_WIDTH-1:0]   result_wb_o,
  output logic                    misalign_wb_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  // Incoming op decode
  logic          is_load, is_store, is_mem, size_illegal, misalign, exc;
  logic [1:0]    size;
  logic [OW-1:0] offset, size_mask;
  logic [NB-1:0] size_bytes;

  assign is_load    = opcode_mem_i == OpLoad;
  assign is_store   = opcode_mem_i == OpStore;
  assign is_mem     = is_load | is_store;
  assign size       = funct3_mem_i[1:0];
  assign offset     = alu_out_mem_i[OW-1:0];
  assign size_mask  = OW'((32'd1 << size) - 32'd1);
  assign size_bytes = NB'((32'd1 << (32'd1 << size)) - 32'd1);
  assign misalign   = |(offset & size_mask);
  assign size_illegal = (is_store & funct3_mem_i[2]) | ((size == 2'd3) && (DATA_WIDTH == 32));
  assign exc        = is_mem & (size_illegal | misalign);

  // Queue and request state
  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d, is_mem_q, is_mem_d;
  logic [DEPTH-1:0]      is_load_q, is_load_d, exc_q, exc_d, rd_en_q, rd_en_d;
  logic [4:0]            rd_addr_q [DEPTH];
  logic [4:0]            rd_addr_d [DEPTH];
  logic [2:0]            funct3_q  [DEPTH];
  logic [2:0]            funct3_d  [DEPTH];
  logic [OW-1:0]         offset_q  [DEPTH];
  logic [OW-1:0]         offset_d  [DEPTH];
  logic [DATA_WIDTH-1:0] result_q  [DEPTH];
  logic [DATA_WIDTH-1:0] result_d  [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  req_valid_q, req_valid_d, req_wen_q, req_wen_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [NB-1:0]         req_wstrb_q, req_wstrb_d;

  logic full, req_free, enq, issue, deq, rsp_fire;

  // Accept rule: excepting and non-memory ops need only a free queue slot
  always_comb begin
    full        = count_q == CW'(DEPTH);
    req_free    = ~req_valid_q | ready_dmem_i;
    ready_mem_o = ~full & (~is_mem | exc | req_free);
    enq         = valid_mem_i & ready_mem_o;
    issue       = enq & is_mem & ~exc;
    deq         = valid_wb_o & ready_wb_i;
  end

  // Request register: loads on issue, holds while stalled, drops when taken
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    req_wen_d   = req_wen_q;
    if (issue) begin
      req_valid_d = 1'b1;
      req_addr_d  = {alu_out_mem_i[DATA_WIDTH-1:OW], {OW{1'b0}}};
      req_wen_d   = is_store;
      req_wstrb_d = is_store ? (size_bytes << offset) : '0;
      req_wdata_d = is_store ? (rs2_data_mem_i << {offset, 3'b000}) : '0;
    end else if (ready_dmem_i) begin
      req_valid_d = 1'b0;
    end
  end

  // Find the oldest memory entry still waiting for its dmem response
  logic          rsp_found;
  logic [PW-1:0] rsp_idx, scan_idx;

  always_comb begin
    rsp_found = 1'b0;
    rsp_idx   = rd_ptr_q;
    scan_idx  = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (!rsp_found && valid_q[scan_idx] && is_mem_q[scan_idx] && !done_q[scan_idx]) begin
        rsp_found = 1'b1;
        rsp_idx   = scan_idx;
      end
    end
  end

  assign ready_rsp_dmem_o = rsp_found;
  assign rsp_fire         = valid_rsp_dmem_i & rsp_found;

  // Load extraction: shift the addressed bytes down, then mask and extend
  logic [2:0]            rsp_f3;
  logic [DATA_WIDTH-1:0] rsp_shift, load_keep, load_val;
  logic                  load_sign;
  int unsigned           load_bits;

  always_comb begin
    rsp_f3    = funct3_q[rsp_idx];
    rsp_shift = rdata_rsp_dmem_i >> {offset_q[rsp_idx], 3'b000};
    load_bits = 32'd8 << rsp_f3[1:0];
    load_keep = '1;
    if (load_bits < DATA_WIDTH) begin
      load_keep = (DATA_WIDTH'(1) << load_bits) - DATA_WIDTH'(1);
    end
    // keep ^ (keep >> 1) isolates the top bit of the access
    load_sign = ~rsp_f3[2] & |(rsp_shift & (load_keep ^ (load_keep >> 1)));
    load_val  = (rsp_shift & load_keep) | (load_sign ? ~load_keep : '0);
  end

  // Queue next state: enqueue at tail, complete on response, retire at head
  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    is_mem_d  = is_mem_q;
    is_load_d = is_load_q;
    exc_d     = exc_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    funct3_d  = funct3_q;
    offset_d  = offset_q;
    result_d  = result_q;
    if (enq) begin
      valid_d[wr_ptr_q]   = 1'b1;
      done_d[wr_ptr_q]    = ~is_mem | exc;
      is_mem_d[wr_ptr_q]  = is_mem;
      is_load_d[wr_ptr_q] = is_load;
      exc_d[wr_ptr_q]     = exc;
      rd_en_d[wr_ptr_q]   = rd_en_mem_i & ~exc;
      rd_addr_d[wr_ptr_q] = rd_addr_mem_i;
      funct3_d[wr_ptr_q]  = funct3_mem_i;
      offset_d[wr_ptr_q]  = offset;
      result_d[wr_ptr_q]  = alu_out_mem_i;
    end
    if (rsp_fire) begin
      done_d[rsp_idx] = 1'b1;
      if (is_load_q[rsp_idx]) begin
        result_d[rsp_idx] = load_val;
      end
    end
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(enq) - CW'(deq);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      done_q      <= '0;
      is_mem_q    <= '0;
      is_load_q   <= '0;
      exc_q       <= '0;
      rd_en_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_addr_q[i] <= '0;
        funct3_q[i]  <= '0;
        offset_q[i]  <= '0;
        result_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      req_wen_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      is_mem_q    <= is_mem_d;
      is_load_q   <= is_load_d;
      exc_q       <= exc_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      result_q    <= result_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_wen_q   <= req_wen_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    valid_dmem_o  = req_valid_q;
    addr_dmem_o   = req_addr_q;
    wdata_dmem_o  = req_wdata_q;
    wstrb_dmem_o  = req_wstrb_q;
    w_en_dmem_o   = req_wen_q;
    valid_wb_o    = valid_q[rd_ptr_q] & done_q[rd_ptr_q];
    rd_addr_wb_o  = rd_addr_q[rd_ptr_q];
    rd_en_wb_o    = rd_en_q[rd_ptr_q];
    result_wb_o   = result_q[rd_ptr_q];
    misalign_wb_o = exc_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_cprv_lsu_stage.sv
// Scoreboard bench for cprv_lsu_stage: stimulus pushes expected dmem requests and wb
// results computed by a byte-level reference model; monitors pop and compare.
module tb_cprv_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem_i, ready_mem_o;
  logic [6:0]  opcode_mem_i;
  logic [2:0]  funct3_mem_i;
  logic [4:0]  rd_addr_mem_i;
  logic        rd_en_mem_i;
  logic [63:0] alu_out_mem_i, rs2_data_mem_i;
  logic        valid_dmem_o, ready_dmem_i;
  logic [63:0] addr_dmem_o, wdata_dmem_o;
  logic [7:0]  wstrb_dmem_o;
  logic        w_en_dmem_o;
  logic        valid_rsp_dmem_i, ready_rsp_dmem_o;
  logic [63:0] rdata_rsp_dmem_i;
  logic        valid_wb_o, ready_wb_i;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [63:0] result_wb_o;
  logic        misalign_wb_o;

  cprv_lsu_stage #(.DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o), .opcode_mem_i(opcode_mem_i),
    .funct3_mem_i(funct3_mem_i), .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
    .alu_out_mem_i(alu_out_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
    .valid_dmem_o(valid_dmem_o), .ready_dmem_i(ready_dmem_i), .addr_dmem_o(addr_dmem_o),
    .wdata_dmem_o(wdata_dmem_o), .wstrb_dmem_o(wstrb_dmem_o), .w_en_dmem_o(w_en_dmem_o),
    .valid_rsp_dmem_i(valid_rsp_dmem_i), .ready_rsp_dmem_o(ready_rsp_dmem_o),
    .rdata_rsp_dmem_i(rdata_rsp_dmem_i),
    .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i), .rd_addr_wb_o(rd_addr_wb_o),
    .rd_en_wb_o(rd_en_wb_o), .result_wb_o(result_wb_o), .misalign_wb_o(misalign_wb_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wen;
    logic [63:0] rdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rden;
    logic [63:0] res;
    logic        mis;
  } wb_t;

  req_t        exp_req[$];
  wb_t         exp_wb[$];
  logic [63:0] rsp_q[$];

  int total = 0;
  int bad   = 0;
  int dmem_mode = 1;  // 0 random, 1 always ready, 2 never ready
  int wb_mode   = 1;
  bit rsp_en    = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic on the address and the dmem word
  function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                input logic [63:0] alu, input logic [63:0] rs2,
                                input logic [63:0] rdata, output bit is_mem, output bit exc,
                                output logic [63:0] res, output logic [63:0] addr,
                                output logic [63:0] wdata, output logic [7:0] strb);
    int          nbytes, off;
    bit          ld, st;
    logic [63:0] v;
    ld     = op == 7'b0000011;
    st     = op == 7'b0100011;
    is_mem = ld | st;
    nbytes = 1 << f3[1:0];
    off    = int'(alu % 64'd8);
    exc    = is_mem && ((st && f3[2]) || (off % nbytes != 0));
    addr   = alu - 64'(off);
    strb   = '0;
    wdata  = '0;
    v      = '0;
    if (!exc) begin
      if (st) begin
        for (int b = 0; b < nbytes; b++) strb[off+b] = 1'b1;
        wdata = rs2 << (8 * off);
      end
      for (int b = 0; b < nbytes; b++) v[8*b +: 8] = rdata[8*(off+b) +: 8];
      if (!f3[2] && nbytes < 8 && v[8*nbytes-1]) begin
        for (int k = 8 * nbytes; k < 64; k++) v[k] = 1'b1;
      end
    end
    res = (ld && !exc) ? v : alu;
  endfunction

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic rden, input logic [63:0] alu, input logic [63:0] rs2,
                      input logic [63:0] rdata, input bit ovr, input logic [63:0] want);
    bit          is_mem, exc, acc;
    logic [63:0] res, addr, wdata;
    logic [7:0]  strb;
    model(op, f3, alu, rs2, rdata, is_mem, exc, res, addr, wdata, strb);
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(posedge clk); #2;
      valid_mem_i    = 1'b1;
      opcode_mem_i   = op;
      funct3_mem_i   = f3;
      rd_addr_mem_i  = rd;
      rd_en_mem_i    = rden;
      alu_out_mem_i  = alu;
      rs2_data_mem_i = rs2;
      @(negedge clk);
      acc = ready_mem_o;
    end
    if (!acc) begin
      chk("ex_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #2;
      valid_mem_i = 1'b0;
      return;
    end
    if (is_mem && !exc) exp_req.push_back('{addr, wdata, strb, op == 7'b0100011, rdata});
    exp_wb.push_back('{rd, rden & ~exc, ovr ? want : res, exc});
  endtask

  task automatic idle();
    @(posedge clk); #2;
    valid_mem_i = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_wb.size() != 0 || exp_req.size() != 0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_left", 64'(exp_wb.size() + exp_req.size()), 64'd0);
  endtask

  // Handshake ready drivers
  initial begin
    ready_dmem_i = 1'b0;
    ready_wb_i   = 1'b0;
    forever begin
      @(posedge clk); #2;
      ready_dmem_i = (dmem_mode == 1) || (dmem_mode == 0 && $urandom_range(0, 3) != 0);
      ready_wb_i   = (wb_mode == 1) || (wb_mode == 0 && $urandom_range(0, 3) != 0);
    end
  end

  // dmem responder: answers fired requests in order with the pre-chosen data
  initial begin
    bit fire;
    valid_rsp_dmem_i = 1'b0;
    rdata_rsp_dmem_i = '0;
    forever begin
      @(negedge clk);
      fire = valid_rsp_dmem_i && ready_rsp_dmem_o;
      @(posedge clk); #2;
      if (fire && rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (rsp_q.size() > 0 && rsp_en && $urandom_range(0, 9) < 7) begin
        valid_rsp_dmem_i = 1'b1;
        rdata_rsp_dmem_i = rsp_q[0];
      end else begin
        valid_rsp_dmem_i = 1'b0;
      end
    end
  end

  // Request monitor
  initial begin
    req_t r;
    forever begin
      @(negedge clk);
      if (rst_n && valid_dmem_o && ready_dmem_i) begin
        if (exp_req.size() == 0) begin
          chk("dmem_unexpected_req", 64'd1, 64'd0);
        end else begin
          r = exp_req.pop_front();
          chk("dmem_addr", addr_dmem_o, r.addr);
          chk("dmem_wdata", wdata_dmem_o, r.wdata);
          chk("dmem_wstrb", 64'(wstrb_dmem_o), 64'(r.wstrb));
          chk("dmem_wen", 64'(w_en_dmem_o), 64'(r.wen));
          rsp_q.push_back(r.rdata);
        end
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (rst_n && valid_wb_o && ready_wb_i) begin
        if (exp_wb.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
        end else begin
          w = exp_wb.pop_front();
          chk("wb_rd_addr", 64'(rd_addr_wb_o), 64'(w.rd));
          chk("wb_rd_en", 64'(rd_en_wb_o), 64'(w.rden));
          chk("wb_result", result_wb_o, w.res);
          chk("wb_misalign", 64'(misalign_wb_o), 64'(w.mis));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    rst_n          = 1'b0;
    valid_mem_i    = 1'b0;
    opcode_mem_i   = 7'h13;
    funct3_mem_i   = '0;
    rd_addr_mem_i  = '0;
    rd_en_mem_i    = 1'b0;
    alu_out_mem_i  = '0;
    rs2_data_mem_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_dmem", 64'(valid_dmem_o), 64'd0);
    chk("rst_valid_wb", 64'(valid_wb_o), 64'd0);
    chk("rst_addr", addr_dmem_o, 64'd0);
    chk("rst_wdata", wdata_dmem_o, 64'd0);
    chk("rst_wstrb", 64'(wstrb_dmem_o), 64'd0);
    chk("rst_result", result_wb_o, 64'd0);
    chk("rst_rd_en", 64'(rd_en_wb_o), 64'd0);
    chk("rst_ready_rsp", 64'(ready_rsp_dmem_o), 64'd0);
    chk("rst_ready_mem", 64'(ready_mem_o), 64'd1);
    rst_n = 1'b1;

    // Non-memory op: result visible the cycle after accept
    send(7'h33, 3'd0, 5'd5, 1'b1, 64'h1234, 64'd0, 64'd0, 1'b1, 64'h1234);
    idle();
    @(negedge clk);
    chk("alu_latency_valid_wb", 64'(valid_wb_o), 64'd1);
    drain();

    // LB / LBU at 0x1003 with the addressed byte 0x80
    send(7'h03, 3'b000, 5'd6, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1'b1,
         64'hFFFF_FFFF_FFFF_FF80);
    send(7'h03, 3'b100, 5'd7, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1'b1,
         64'h80);
    idle();
    drain();

    // Misaligned LW: no request, flagged the next cycle
    send(7'h03, 3'b010, 5'd8, 1'b1, 64'h1002, 64'd0, 64'd0, 1'b0, 64'd0);
    idle();
    @(negedge clk);
    chk("mis_valid_wb", 64'(valid_wb_o), 64'd1);
    chk("mis_flag", 64'(misalign_wb_o), 64'd1);
    chk("mis_rd_en", 64'(rd_en_wb_o), 64'd0);
    chk("mis_no_req", 64'(valid_dmem_o), 64'd0);
    drain();

    // SH at 0x2006 held while dmem stalls
    dmem_mode = 2;
    send(7'h23, 3'b001, 5'd0, 1'b0, 64'h2006, 64'hABCD, 64'd0, 1'b0, 64'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(valid_dmem_o), 64'd1);
      chk("stall_addr", addr_dmem_o, 64'h2000);
      chk("stall_wdata", wdata_dmem_o, 64'hABCD_0000_0000_0000);
      chk("stall_wstrb", 64'(wstrb_dmem_o), 64'hC0);
    end
    dmem_mode = 1;
    drain();

    // Fill the queue with four loads, responses and wb held off
    wb_mode = 2;
    rsp_en  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(7'h03, 3'b011, 5'(i + 1), 1'b1, 64'h4000 + 64'(8 * i), 64'd0,
           64'h1111_0000_0000_0000 * 64'(i + 1) + 64'(i), 1'b0, 64'd0);
    end
    @(posedge clk); #2;
    valid_mem_i  = 1'b1;
    opcode_mem_i = 7'h33;
    @(negedge clk);
    chk("full_ready_mem", 64'(ready_mem_o), 64'd0);
    chk("full_no_wb", 64'(valid_wb_o), 64'd0);
    idle();
    rsp_en  = 1'b1;
    wb_mode = 1;
    drain();

    // Randomized traffic against the model
    dmem_mode = 0;
    wb_mode   = 0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 7'b0000011;
        4, 5, 6:    op = 7'b0100011;
        default: begin
          op = 7'($urandom);
          if (op == 7'b0000011 || op == 7'b0100011) op = 7'h13;
        end
      endcase
      send(op, 3'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 64'd0);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    dmem_mode = 1;
    wb_mode   = 1;
    drain();

    // Reset in the middle of traffic clears both valids at once
    dmem_mode = 2;
    wb_mode   = 2;
    send(7'h33, 3'd0, 5'd9, 1'b1, 64'h55, 64'd0, 64'd0, 1'b0, 64'd0);
    send(7'h23, 3'b011, 5'd0, 1'b0, 64'h3000, 64'h77, 64'd0, 1'b0, 64'd0);
    idle();
    @(negedge clk);
    chk("pre_rst_valid_wb", 64'(valid_wb_o), 64'd1);
    chk("pre_rst_valid_dmem", 64'(valid_dmem_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_dmem", 64'(valid_dmem_o), 64'd0);
    chk("mid_rst_valid_wb", 64'(valid_wb_o), 64'd0);
    chk("mid_rst_result", result_wb_o, 64'd0);
    exp_req.delete();
    exp_wb.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
